gate_checker: RTL and testbench

Synthesizable exhaustive checker for small combinational gates such as the NAND-built `my_and`, `my_or` and `my_not`. It drives every input combination onto a device under test and samples the device's response. Each response is compared against an expected truth table, and the block reports a pass/fail verdict, an error count and the first failing vector. It is the response-side counterpart to a stimulus-only bench and lets gate-level cells be self-checked in simulation or on hardware.

---
 rtl/gate_checker_pkg.sv | 20 ++
 rtl/gate_checker_settle_timer.sv | 46 ++++
 rtl/gate_checker.sv | 160 ++++++++++++++++
 tb/tb_gate_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_checker_pkg.sv
// Shared definitions for gate_checker: FSM state encoding, legal parameter
// ranges and the settle counter width.
package gate_checker_pkg;

  localparam int unsigned N_IN_MIN   = 1;
  localparam int unsigned N_IN_MAX   = 4;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;

  // Wide enough for SETTLE_MAX-1.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/gate_checker_settle_timer.sv
// Loadable down-counter that times the settle window before each sample.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : reload the counter with LOAD_VAL
//   dec_i     : decrement (stops at zero)
//   zero_o    : registered flag, high while the count is zero
module gate_checker_settle_timer
  import gate_checker_pkg::*;
#(
  parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Zero flag is registered from the next count so it is valid the cycle
  // after a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/gate_checker.sv
// Exhaustive checker for a small combinational gate: sweeps every input
// vector, waits SETTLE cycles, samples the response and compares it with a
// captured truth table.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a run (accepted in IDLE only)
//   truth     : expected response table, bit k for vector k, captured at start
//   stim      : vector driven to the gate under test
//   resp      : gate response
//   busy      : run in progress
//   done      : one-cycle completion pulse
//   pass      : last run had no mismatches
//   err_cnt   : mismatch count of the current/last run
//   fail_vec  : first mismatching vector
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2**N_IN-1:0]    truth,
  output logic [N_IN-1:0]       stim,
  input  logic                  resp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         err_cnt,
  output logic [N_IN-1:0]       fail_vec
);

  localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};

  // Elaboration-time parameter range check.
  if ((N_IN < N_IN_MIN) || (N_IN > N_IN_MAX) ||
      (SETTLE < SETTLE_MIN) || (SETTLE > SETTLE_MAX)) begin : g_bad_param
    $error("gate_checker: N_IN or SETTLE out of legal range");
  end

  state_t               state_q, state_d;
  logic [2**N_IN-1:0]   truth_q, truth_d;
  logic [N_IN-1:0]      stim_q, stim_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [N_IN:0]        err_q, err_d;
  logic [N_IN-1:0]      fail_q, fail_d;
  logic                 tmr_load, tmr_dec, tmr_zero;
  logic                 mismatch;

  gate_checker_settle_timer #(
    .LOAD_VAL (CNT_W'(SETTLE - 1))
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    truth_d  = truth_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    mismatch = (resp != truth_q[stim_q]);

    case (state_q)
      ST_IDLE: begin
        stim_d = '0;
        if (start) begin
          truth_d  = truth;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + (N_IN + 1)'(1);
          if (err_q == '0) begin
            fail_d = stim_q;
          end
        end
        // Last-vector test comes before the increment, so stim never wraps.
        if (stim_q == STIM_LAST) begin
          state_d = ST_REPORT;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
        end else begin
          stim_d   = stim_q + N_IN'(1);
          tmr_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end

      ST_REPORT: begin
        stim_d  = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      truth_q <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      truth_q <= truth_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign stim     = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three instances (N_IN=2/SETTLE=1, N_IN=2/SETTLE=3,
// N_IN=1/SETTLE=1). Each gate under test is a response table indexed by stim.
module tb_gate_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s  [3];
  logic [15:0] truth_s  [3];
  logic [15:0] resp_tab [3];
  logic [3:0]  stim_s   [3];
  logic        resp_s   [3];
  logic        busy_s   [3];
  logic        done_s   [3];
  logic        pass_s   [3];
  logic [4:0]  err_s    [3];
  logic [3:0]  fail_s   [3];

  int vec_cnt  = 0;
  int miscomp  = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int unsigned N  = (gi == 2) ? 1 : 2;
    localparam int unsigned S  = (gi == 1) ? 3 : 1;
    localparam int unsigned NV = 1 << N;
    logic [N-1:0] stim_w;
    logic [N:0]   err_w;
    logic [N-1:0] fail_w;

    gate_checker #(.N_IN(N), .SETTLE(S)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s[gi]),
      .truth    (truth_s[gi][NV-1:0]),
      .stim     (stim_w),
      .resp     (resp_s[gi]),
      .busy     (busy_s[gi]),
      .done     (done_s[gi]),
      .pass     (pass_s[gi]),
      .err_cnt  (err_w),
      .fail_vec (fail_w)
    );

    assign stim_s[gi] = 4'(stim_w);
    assign err_s[gi]  = 5'(err_w);
    assign fail_s[gi] = 4'(fail_w);
    assign resp_s[gi] = resp_tab[gi][stim_w];
  end

  function automatic int n_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int s_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: count vectors where the gate's table disagrees with truth.
  task automatic model(input int i, input logic [15:0] tr, input logic [15:0] rt,
                       output int e_err, output int e_fail, output bit e_pass);
    int nv;
    nv = 1 << n_of(i);
    e_err  = 0;
    e_fail = 0;
    for (int v = 0; v < nv; v++) begin
      if (tr[v] != rt[v]) begin
        if (e_err == 0) e_fail = v;
        e_err++;
      end
    end
    e_pass = (e_err == 0);
  endtask

  // Wait at a falling edge until instance i is in IDLE (not busy, not done).
  task automatic wait_idle(input int i);
    int g;
    g = 0;
    @(negedge clk);
    while ((busy_s[i] || done_s[i]) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("idle_wait_timeout", 32'(g < 100), 32'd1);
  endtask

  // Wait for done after the start edge, checking the sweep each cycle.
  task automatic sweep(input int i, input string nm, input int e_err,
                       input int e_fail, input bit e_pass);
    int sp1, edges, t;
    sp1   = s_of(i) + 1;
    edges = (1 << n_of(i)) * sp1;
    for (t = 1; t <= edges + 20; t++) begin
      @(posedge clk);
      #1;
      if (done_s[i]) break;
      if (t < edges)
        chk({nm, "_step"}, 32'({busy_s[i], done_s[i], stim_s[i]}),
            32'({1'b1, 1'b0, 4'(t / sp1)}));
    end
    chk({nm, "_latency"}, 32'(t), 32'(edges));
    chk({nm, "_busy_at_done"}, 32'(busy_s[i]), 32'd0);
    chk({nm, "_stim_at_done"}, 32'(stim_s[i]), 32'((1 << n_of(i)) - 1));
    chk({nm, "_err_cnt"}, 32'(err_s[i]), 32'(e_err));
    chk({nm, "_pass"}, 32'(pass_s[i]), 32'(e_pass));
    if (e_err != 0) chk({nm, "_fail_vec"}, 32'(fail_s[i]), 32'(e_fail));
  endtask

  // Full run: start, sweep, then check the done pulse ends and results hold.
  task automatic run(input int i, input logic [15:0] tr, input logic [15:0] rt,
                     input int e_err, input int e_fail, input bit e_pass,
                     input string nm);
    wait_idle(i);
    truth_s[i]  = tr;
    resp_tab[i] = rt;
    start_s[i]  = 1'b1;
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
    truth_s[i] = ~tr;  // must not affect the run in progress
    sweep(i, nm, e_err, e_fail, e_pass);
    @(posedge clk);
    #1;
    chk({nm, "_after"}, 32'({done_s[i], busy_s[i], stim_s[i], err_s[i], pass_s[i]}),
        32'({1'b0, 1'b0, 4'd0, 5'(e_err), e_pass}));
  endtask

  typedef struct {
    int          inst;
    logic [15:0] truth;
    logic [15:0] rtab;
    int          e_err;
    int          e_fail;
    bit          e_pass;
  } vec_t;

  vec_t tab [6];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   e_err, e_fail, ndone, i;
    bit   e_pass;
    logic [15:0] tr, rt;

    tab[0] = '{0, 16'b1000, 16'b1000, 0, 0, 1'b1};  // my_and
    tab[1] = '{0, 16'b1111, 16'b1110, 1, 0, 1'b0};  // my_or, wrong truth at 0
    tab[2] = '{2, 16'b01,   16'b01,   0, 0, 1'b1};  // my_not
    tab[3] = '{1, 16'b1000, 16'b0000, 1, 3, 1'b0};  // resp tied 0, SETTLE=3
    tab[4] = '{0, 16'b0000, 16'b1111, 4, 0, 1'b0};  // every vector wrong
    tab[5] = '{1, 16'b0110, 16'b0100, 1, 1, 1'b0};

    for (int k = 0; k < 3; k++) begin
      start_s[k]  = 1'b0;
      truth_s[k]  = '0;
      resp_tab[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk("reset_state", 32'({stim_s[k], busy_s[k], done_s[k], pass_s[k], err_s[k], fail_s[k]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++)
      run(tab[k].inst, tab[k].truth, tab[k].rtab, tab[k].e_err, tab[k].e_fail,
          tab[k].e_pass, $sformatf("tab%0d", k));

    // Mid-run start pulse is ignored; start then held high for back-to-back runs.
    wait_idle(0);
    truth_s[0]  = 16'b1000;
    resp_tab[0] = 16'b1111;
    start_s[0]  = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      start_s[0] = (t == 3) || (t >= 6);
      @(posedge clk);
      #1;
      chk("midrun_step", 32'({busy_s[0], done_s[0], stim_s[0]}),
          (t < 8) ? 32'({1'b1, 1'b0, 4'(t / 2)}) : 32'({1'b0, 1'b1, 4'd3}));
    end
    chk("midrun_err", 32'({err_s[0], fail_s[0], pass_s[0]}), 32'({5'd3, 4'd0, 1'b0}));
    @(posedge clk);
    #1;
    chk("b2b_idle_gap", 32'({busy_s[0], done_s[0], stim_s[0], err_s[0]}),
        32'({1'b0, 1'b0, 4'd0, 5'd3}));
    @(posedge clk);
    #1;
    chk("b2b_restart", 32'({busy_s[0], err_s[0], pass_s[0], stim_s[0]}),
        32'({1'b1, 5'd0, 1'b0, 4'd0}));
    @(negedge clk);
    start_s[0] = 1'b0;
    sweep(0, "b2b_second", 3, 0, 1'b0);

    // Reset during WAIT of vector 2: no done pulse, then a clean full run.
    run(0, 16'b1000, 16'b1000, 0, 0, 1'b1, "pre_rst");
    wait_idle(0);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_setup_stim", 32'(stim_s[0]), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_midrun", 32'({stim_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], fail_s[0]}), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_s[0]) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'd0);
    run(0, 16'b1000, 16'b1000, 0, 0, 1'b1, "post_rst");

    // Randomized runs against the reference model.
    for (int r = 0; r < 24; r++) begin
      i  = $urandom_range(0, 2);
      tr = 16'($urandom);
      rt = ($urandom_range(0, 2) == 0) ? tr : 16'($urandom);
      model(i, tr, rt, e_err, e_fail, e_pass);
      run(i, tr, rt, e_err, e_fail, e_pass, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
    $finish;
  end

endmodule
